// File: rtl/feature_cache_mb_pkg.sv
// -----------------------------------------------------------------------------
// pkg_feature_cache_mb
// Shared types and helpers for the multi-read-port feature cache.
//   state_t      : clear-engine state (IDLE / CLEAR)
//   DEF_*        : default parameter values of feature_cache_mb
//   get_slice()  : extracts port slice idx of a packed per-port bus
// -----------------------------------------------------------------------------
package pkg_feature_cache_mb;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int DEF_WORD_SIZE  = 8;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_WORDS      = 1024;
    localparam int DEF_NUM_RD     = 2;
    localparam int DEF_OUT_REG    = 1;

    // Widest slice / bus the helper handles: 4 ports of up to 64 bits each.
    localparam int MAX_SLICE_W = 64;
    localparam int MAX_BUS_W   = 4 * MAX_SLICE_W;

    // Returns bits [idx*width +: width] of a zero-extended packed bus,
    // right-aligned; callers truncate to their own slice width.
    function automatic logic [MAX_SLICE_W-1:0] get_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   idx,
        input int                   width
    );
        logic [MAX_BUS_W-1:0]   shifted;
        logic [MAX_SLICE_W-1:0] mask;
        shifted = bus >> (idx * width);
        mask    = ~({MAX_SLICE_W{1'b1}} << width);
        return shifted[MAX_SLICE_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/feature_cache_mb_bank.sv
// -----------------------------------------------------------------------------
// fc_sdp_bank
// Simple dual-port RAM replica: one write port, one synchronous read port.
// The read is read-first: a same-address write in the same cycle is not seen
// (the top level bypasses that case itself). Read data holds while re is low.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read strobe and address
//   rdata        : registered read data
// -----------------------------------------------------------------------------
module fc_sdp_bank
    import pkg_feature_cache_mb::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int WORDS     = DEF_WORDS,
    parameter int IDX_W     = DEF_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic                 re,
    input  logic [IDX_W-1:0]     raddr,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem [WORDS];
    logic [WORD_SIZE-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/feature_cache_mb.sv
// -----------------------------------------------------------------------------
// feature_cache_mb
// Descriptor store with NUM_RD independent read ports (one RAM replica per
// port), a shared write port, per-entry valid bits, same-cycle write->read
// bypass and a sequenced clear engine.
//   clk, rst             : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data: write port; wr_drop pulses a cycle after a drop
//   rd_en/rd_addr        : per-port read strobes and packed addresses
//   rd_data/rd_valid/rd_hit : packed read data, data strobe, entry valid bit
//   clr_req/clr_busy     : start clear sweep / sweep in progress
// Read latency is 1 + OUT_REG cycles.
// -----------------------------------------------------------------------------
module feature_cache_mb
    import pkg_feature_cache_mb::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WORDS      = DEF_WORDS,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int OUT_REG    = DEF_OUT_REG
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [WORD_SIZE-1:0]         wr_data,
    output logic                         wr_drop,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*WORD_SIZE-1:0]  rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic [NUM_RD-1:0]            rd_hit,
    input  logic                         clr_req,
    output logic                         clr_busy
);

    localparam int                    IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_WIDTH:0]   WORDS_LIM = (ADDR_WIDTH + 1)'(WORDS);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(WORDS - 1);

    // ------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
    logic             clearing;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            CLEAR: begin
                // clr_req is deliberately not looked at here: no restart.
                if (clr_ptr_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    clr_ptr_d = clr_ptr_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clearing = (state_q == CLEAR);
        clr_busy = clearing;
    end

    // ------------------------------------------------------------------
    // Write path: accepted only in IDLE, in range, and not when a clear is
    // being requested in the same cycle (the clear wins).
    // ------------------------------------------------------------------
    logic                 wr_in_range, wr_ok;
    logic [IDX_W-1:0]     wr_idx;
    logic                 wr_drop_q, wr_drop_d;
    logic                 bank_we;
    logic [IDX_W-1:0]     bank_waddr;
    logic [WORD_SIZE-1:0] bank_wdata;

    always_comb begin
        wr_in_range = ({1'b0, wr_addr} < WORDS_LIM);
        wr_idx      = wr_addr[IDX_W-1:0];
        wr_ok       = wr_en && !rst && !clearing && !clr_req && wr_in_range;
        wr_drop_d   = wr_en && (clearing || clr_req || !wr_in_range);
        // Nothing touches the RAM during the reset cycle, so an aborted
        // sweep leaves the entry it was about to clear untouched.
        bank_we     = !rst && (clearing || wr_ok);
        bank_waddr  = clearing ? clr_ptr_q : wr_idx;
        bank_wdata  = clearing ? '0 : wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
        end
    end

    assign wr_drop = wr_drop_q;

    // ------------------------------------------------------------------
    // Valid bits
    // ------------------------------------------------------------------
    logic [WORDS-1:0] valid_q, valid_d;

    always_comb begin
        valid_d = valid_q;
        if (clearing) begin
            valid_d[clr_ptr_q] = 1'b0;
        end else if (wr_ok) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
        logic [ADDR_WIDTH-1:0] addr;
        logic [IDX_W-1:0]      idx;
        logic                  in_range, bypass;
        logic [WORD_SIZE-1:0]  bank_dout, s1_data;

        logic                  s1_valid_q,    s1_valid_d;
        logic                  s1_in_range_q, s1_in_range_d;
        logic                  s1_bypass_q,   s1_bypass_d;
        logic [WORD_SIZE-1:0]  s1_byp_data_q, s1_byp_data_d;
        logic                  s1_hit_q,      s1_hit_d;

        always_comb begin
            addr          = ADDR_WIDTH'(get_slice(MAX_BUS_W'(rd_addr), gi, ADDR_WIDTH));
            idx           = addr[IDX_W-1:0];
            in_range      = ({1'b0, addr} < WORDS_LIM);
            bypass        = wr_ok && (addr == wr_addr);
            s1_valid_d    = rd_en[gi];
            s1_in_range_d = s1_in_range_q;
            s1_bypass_d   = s1_bypass_q;
            s1_byp_data_d = s1_byp_data_q;
            s1_hit_d      = s1_hit_q;
            // Side information only updates on a read so the output holds
            // its last value between reads, just like the bank.
            if (rd_en[gi]) begin
                s1_in_range_d = in_range;
                s1_bypass_d   = bypass;
                s1_byp_data_d = wr_data;
                s1_hit_d      = in_range && !clearing && (bypass || valid_q[idx]);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid_q    <= 1'b0;
                s1_in_range_q <= 1'b0;
                s1_bypass_q   <= 1'b0;
                s1_byp_data_q <= '0;
                s1_hit_q      <= 1'b0;
            end else begin
                s1_valid_q    <= s1_valid_d;
                s1_in_range_q <= s1_in_range_d;
                s1_bypass_q   <= s1_bypass_d;
                s1_byp_data_q <= s1_byp_data_d;
                s1_hit_q      <= s1_hit_d;
            end
        end

        fc_sdp_bank #(
            .WORD_SIZE (WORD_SIZE),
            .WORDS     (WORDS),
            .IDX_W     (IDX_W)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .re    (rd_en[gi] && in_range),
            .raddr (idx),
            .rdata (bank_dout)
        );

        assign s1_data = !s1_in_range_q ? '0 :
                         (s1_bypass_q ? s1_byp_data_q : bank_dout);

        if (OUT_REG != 0) begin : g_oreg
            logic                 out_valid_q, out_valid_d;
            logic                 out_hit_q,   out_hit_d;
            logic [WORD_SIZE-1:0] out_data_q,  out_data_d;

            always_comb begin
                out_valid_d = s1_valid_q;
                out_hit_d   = s1_valid_q && s1_hit_q;
                out_data_d  = s1_valid_q ? s1_data : out_data_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    out_hit_q   <= 1'b0;
                    out_data_q  <= '0;
                end else begin
                    out_valid_q <= out_valid_d;
                    out_hit_q   <= out_hit_d;
                    out_data_q  <= out_data_d;
                end
            end

            assign rd_valid[gi]                         = out_valid_q;
            assign rd_hit[gi]                           = out_hit_q;
            assign rd_data[gi*WORD_SIZE +: WORD_SIZE]   = out_data_q;
        end else begin : g_noreg
            assign rd_valid[gi]                         = s1_valid_q;
            assign rd_hit[gi]                           = s1_valid_q && s1_hit_q;
            assign rd_data[gi*WORD_SIZE +: WORD_SIZE]   = s1_data;
        end
    end

endmodule

// File: tb/tb_feature_cache_mb.sv
// -----------------------------------------------------------------------------
// tb_feature_cache_mb
// Self-checking bench for feature_cache_mb (WORDS=16, ADDR_WIDTH=5, 2 ports,
// output register on). A behavioural model (arrays + a clear countdown)
// produces the expected outputs for every cycle.
// -----------------------------------------------------------------------------
module tb_feature_cache_mb;

    localparam int WS = 8;
    localparam int AW = 5;
    localparam int WD = 16;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [WS-1:0]     wr_data;
    logic              wr_drop;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*WS-1:0]  rd_data;
    logic [NR-1:0]     rd_valid;
    logic [NR-1:0]     rd_hit;
    logic              clr_req;
    logic              clr_busy;

    int checks = 0;
    int errors = 0;

    feature_cache_mb #(
        .WORD_SIZE (WS), .ADDR_WIDTH (AW), .WORDS (WD), .NUM_RD (NR), .OUT_REG (1)
    ) dut (
        .clk (clk), .rst (rst),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .wr_drop (wr_drop),
        .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data),
        .rd_valid (rd_valid), .rd_hit (rd_hit),
        .clr_req (clr_req), .clr_busy (clr_busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [WS-1:0] m_mem   [32];
    bit            m_valid [32];
    int            m_clr_left = 0;
    bit            p1_v [NR];
    bit            p1_h [NR];
    logic [WS-1:0] p1_d [NR];
    bit            exp_rd_valid [NR];
    bit            exp_rd_hit   [NR];
    logic [WS-1:0] exp_rd_data  [NR];
    bit            exp_wr_drop;
    bit            exp_clr_busy;

    // Advance one clock: evaluate this cycle's inputs against the model,
    // then step to just after the rising edge.
    task automatic tick();
        bit            nv [NR];
        bit            nh [NR];
        logic [WS-1:0] nd [NR];
        bit busy, wr_acc, drop;
        int a;
        busy   = (m_clr_left > 0);
        wr_acc = wr_en && !rst && !busy && !clr_req && (int'(wr_addr) < WD);
        drop   = wr_en && (busy || clr_req || int'(wr_addr) >= WD);
        for (int p = 0; p < NR; p++) begin
            a     = int'(rd_addr[p*AW +: AW]);
            nv[p] = rd_en[p];
            if (a >= WD) begin
                nd[p] = '0; nh[p] = 1'b0;
            end else if (wr_acc && int'(wr_addr) == a) begin
                nd[p] = wr_data; nh[p] = 1'b1;
            end else begin
                nd[p] = m_mem[a]; nh[p] = !busy && m_valid[a];
            end
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
            m_clr_left = 0;
            for (int p = 0; p < NR; p++) begin
                p1_v[p] = 0; p1_h[p] = 0; p1_d[p] = '0;
                exp_rd_valid[p] = 0; exp_rd_hit[p] = 0; exp_rd_data[p] = '0;
            end
            exp_wr_drop  = 0;
            exp_clr_busy = 0;
        end else begin
            if (busy) begin
                m_mem[WD - m_clr_left]   = '0;
                m_valid[WD - m_clr_left] = 1'b0;
                m_clr_left--;
            end else if (clr_req) begin
                m_clr_left = WD;
            end else if (wr_acc) begin
                m_mem[wr_addr]   = wr_data;
                m_valid[wr_addr] = 1'b1;
            end
            for (int p = 0; p < NR; p++) begin
                exp_rd_valid[p] = p1_v[p];
                exp_rd_hit[p]   = p1_v[p] && p1_h[p];
                if (p1_v[p]) exp_rd_data[p] = p1_d[p];
                p1_v[p] = nv[p]; p1_h[p] = nh[p]; p1_d[p] = nd[p];
            end
            exp_wr_drop  = drop;
            exp_clr_busy = (m_clr_left > 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = '0; wr_data = '0;
        rd_en = '0; rd_addr = '0; clr_req = 0;
    endtask

    task automatic set_rd(input int p, input int addr);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(addr);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1; tick(); tick(); rst = 0;
        checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL reset rd_valid: got %b expected 00", rd_valid); end
        checks++; if (rd_hit !== 2'b00) begin errors++; $display("FAIL reset rd_hit: got %b expected 00", rd_hit); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset rd_data: got %h expected 0000", rd_data); end
        checks++; if (wr_drop !== 1'b0 || clr_busy !== 1'b0) begin errors++; $display("FAIL reset wr_drop/clr_busy: got %b/%b expected 0/0", wr_drop, clr_busy); end
        set_rd(0, 7); tick(); idle_inputs(); tick();
        checks++; if (rd_valid[0] !== 1'b1 || rd_hit[0] !== 1'b0) begin errors++; $display("FAIL reset_read7 valid/hit: got %b/%b expected 1/0", rd_valid[0], rd_hit[0]); end
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        idle_inputs(); wr_en = 1; wr_addr = 5; wr_data = 8'hA5; tick();
        idle_inputs(); set_rd(0, 5); set_rd(1, 5); tick();
        idle_inputs();
        checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL write_read latency: got rd_valid %b expected 00 at +1", rd_valid); end
        tick();
        for (int p = 0; p < NR; p++) begin
            checks++;
            if (rd_valid[p] !== 1'b1 || rd_hit[p] !== 1'b1 || rd_data[p*WS +: WS] !== 8'hA5 || 8'hA5 !== exp_rd_data[p]) begin
                errors++; $display("FAIL write_read port%0d: got v=%b h=%b d=%h expected v=1 h=1 d=a5", p, rd_valid[p], rd_hit[p], rd_data[p*WS +: WS]);
            end
        end
        $display("test_write_read done");
    endtask

    task automatic test_bypass();
        idle_inputs(); wr_en = 1; wr_addr = 9; wr_data = 8'h42; tick();
        idle_inputs(); wr_en = 1; wr_addr = 9; wr_data = 8'h3C; set_rd(1, 9); tick();
        idle_inputs(); tick();
        checks++;
        if (rd_valid[1] !== 1'b1 || rd_hit[1] !== 1'b1 || rd_data[WS +: WS] !== 8'h3C) begin
            errors++; $display("FAIL bypass port1: got v=%b h=%b d=%h expected v=1 h=1 d=3c", rd_valid[1], rd_hit[1], rd_data[WS +: WS]);
        end
        // read at t, write same address at t+1 -> old data
        set_rd(0, 9); tick();
        idle_inputs(); wr_en = 1; wr_addr = 9; wr_data = 8'h5A; tick();
        idle_inputs();
        checks++;
        if (rd_valid[0] !== 1'b1 || rd_data[0 +: WS] !== 8'h3C) begin
            errors++; $display("FAIL read_then_write port0: got v=%b d=%h expected v=1 d=3c", rd_valid[0], rd_data[0 +: WS]);
        end
        $display("test_bypass done");
    endtask

    task automatic test_sweep();
        int cnt;
        idle_inputs(); clr_req = 1; tick(); clr_req = 0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            checks++; if (clr_busy !== exp_clr_busy) begin errors++; $display("FAIL sweep clr_busy cyc%0d: got %b expected %b", i, clr_busy, exp_clr_busy); end
            if (clr_busy) cnt++;
            wr_en = (i == 3); wr_addr = 4; wr_data = 8'h99;
            tick();
            if (i == 3) begin
                checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL sweep wr_drop: got %b expected 1", wr_drop); end
            end
        end
        wr_en = 0;
        checks++; if (cnt != WD) begin errors++; $display("FAIL sweep busy_len: got %0d expected %0d", cnt, WD); end
        for (int k = 0; k < 4; k++) begin
            idle_inputs(); set_rd(0, $urandom_range(0, WD-1)); set_rd(1, $urandom_range(0, WD-1)); tick();
            idle_inputs(); tick();
            checks++;
            if (rd_valid !== 2'b11 || rd_hit !== 2'b00 || rd_data !== 16'h0) begin
                errors++; $display("FAIL sweep post_read%0d: got v=%b h=%b d=%h expected v=11 h=00 d=0000", k, rd_valid, rd_hit, rd_data);
            end
        end
        $display("test_sweep done");
    endtask

    task automatic test_clr_collision();
        bit done;
        idle_inputs(); clr_req = 1; wr_en = 1; wr_addr = 3; wr_data = 8'hFF; set_rd(1, 3); tick();
        idle_inputs();
        checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL collision wr_drop: got %b expected 1", wr_drop); end
        tick();
        checks++;
        if (rd_valid[1] !== 1'b1 || rd_hit[1] !== 1'b0 || rd_data[WS +: WS] !== 8'h00) begin
            errors++; $display("FAIL collision same_cycle_read: got v=%b h=%b d=%h expected v=1 h=0 d=00", rd_valid[1], rd_hit[1], rd_data[WS +: WS]);
        end
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (clr_busy === 1'b0) done = 1; else tick();
        end
        checks++; if (!done) begin errors++; $display("FAIL collision sweep_end: got busy=%b expected 0 within 40 cycles", clr_busy); end
        set_rd(0, 3); tick(); idle_inputs(); tick();
        checks++;
        if (rd_valid[0] !== 1'b1 || rd_hit[0] !== 1'b0 || rd_data[0 +: WS] !== 8'h00) begin
            errors++; $display("FAIL collision read3: got v=%b h=%b d=%h expected v=1 h=0 d=00", rd_valid[0], rd_hit[0], rd_data[0 +: WS]);
        end
        $display("test_clr_collision done");
    endtask

    task automatic test_reset_mid_sweep();
        idle_inputs(); clr_req = 1; tick(); clr_req = 0;
        tick(); tick(); tick();
        rst = 1; tick(); rst = 0;
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_sweep clr_busy: got %b expected 0", clr_busy); end
        wr_en = 1; wr_addr = 2; wr_data = 8'h11; tick();
        idle_inputs();
        checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL rst_mid_sweep wr_drop: got %b expected 0", wr_drop); end
        set_rd(1, 2); tick(); idle_inputs(); tick();
        checks++;
        if (rd_valid[1] !== 1'b1 || rd_hit[1] !== 1'b1 || rd_data[WS +: WS] !== 8'h11) begin
            errors++; $display("FAIL rst_mid_sweep read2: got v=%b h=%b d=%h expected v=1 h=1 d=11", rd_valid[1], rd_hit[1], rd_data[WS +: WS]);
        end
        $display("test_reset_mid_sweep done");
    endtask

    task automatic test_out_of_range();
        idle_inputs(); wr_en = 1; wr_addr = 20; wr_data = 8'h5E; set_rd(0, 20); set_rd(1, 31); tick();
        idle_inputs();
        checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL oor wr_drop: got %b expected 1", wr_drop); end
        tick();
        checks++;
        if (rd_valid !== 2'b11 || rd_hit !== 2'b00 || rd_data !== 16'h0) begin
            errors++; $display("FAIL oor read: got v=%b h=%b d=%h expected v=11 h=00 d=0000", rd_valid, rd_hit, rd_data);
        end
        $display("test_out_of_range done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            idle_inputs();
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = AW'($urandom_range(0, 19));
            wr_data = WS'($urandom);
            clr_req = ($urandom_range(0, 63) == 0);
            for (int p = 0; p < NR; p++) begin
                if ($urandom_range(0, 3) != 0)
                    set_rd(p, ($urandom_range(0, 2) == 0) ? int'(wr_addr) : int'($urandom_range(0, 19)));
            end
            tick();
            for (int p = 0; p < NR; p++) begin
                checks++;
                if (rd_valid[p] !== exp_rd_valid[p] || rd_hit[p] !== exp_rd_hit[p] || rd_data[p*WS +: WS] !== exp_rd_data[p]) begin
                    errors++; $display("FAIL random cyc%0d port%0d: got v=%b h=%b d=%h expected v=%b h=%b d=%h",
                        c, p, rd_valid[p], rd_hit[p], rd_data[p*WS +: WS], exp_rd_valid[p], exp_rd_hit[p], exp_rd_data[p]);
                end
            end
            checks++;
            if (wr_drop !== exp_wr_drop || clr_busy !== exp_clr_busy) begin
                errors++; $display("FAIL random cyc%0d ctrl: got drop=%b busy=%b expected drop=%b busy=%b", c, wr_drop, clr_busy, exp_wr_drop, exp_clr_busy);
            end
        end
        idle_inputs();
        $display("test_random done");
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_bypass();
        test_sweep();
        test_clr_collision();
        test_reset_mid_sweep();
        test_out_of_range();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/feature_cache_mb.md
# feature_cache_mb

Multi-read-port, parametrised successor to the single-port feature cache in the openCV feature pipeline. It holds one descriptor word per feature slot and serves NUM_RD independent readers, one bank replica per reader, all sharing a single write port. Each entry carries a valid bit. A read-during-write to the same address returns the new data. A sequenced clear engine zeroes the whole store without a reset.

## Interface
Parameters:
- WORD_SIZE, 8: data width in bits.
- ADDR_WIDTH, 10: address width.
- WORDS, 1024: depth; must satisfy WORDS ≤ 2^ADDR_WIDTH.
- NUM_RD, 2: number of read ports, 1..4.
- OUT_REG, 1: 0 gives unregistered bank output; 1 adds an output register stage.

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- wr_en, in, 1: write strobe.
- wr_addr, in, ADDR_WIDTH: write address.
- wr_data, in, WORD_SIZE: write data.
- wr_drop, out, 1: one-cycle pulse when a write is discarded.
- rd_en, in, NUM_RD: per-port read strobe.
- rd_addr, in, NUM_RD*ADDR_WIDTH: packed read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data, out, NUM_RD*WORD_SIZE: packed read data.
- rd_valid, out, NUM_RD: per-port data-valid strobe.
- rd_hit, out, NUM_RD: the entry's valid bit, qualified by rd_valid.
- clr_req, in, 1: start a clear sweep; sampled in IDLE only.
- clr_busy, out, 1: high while a sweep is in progress.

## Operation
- Write: when wr_en is high and the block is in IDLE, every bank replica writes wr_data at wr_addr, and valid[wr_addr] is set.
- Read: port i reads bank i at rd_addr[i]. The bank output is held between reads.
- Bypass: if wr_en is high and rd_addr[i] equals wr_addr in the same cycle, port i returns wr_data with rd_hit=1.
- Out-of-range addresses (≥ WORDS):
  - Writes are dropped and wr_drop pulses.
  - Reads return data 0 with rd_hit=0, and still assert rd_valid.
- FSM has two states, IDLE and CLEAR.
  - IDLE → CLEAR on clr_req. clr_ptr is loaded with 0 and clr_busy rises the next cycle.
  - In CLEAR, each cycle writes 0 to all banks at clr_ptr, clears valid[clr_ptr], then increments clr_ptr.
  - CLEAR → IDLE after clr_ptr reaches WORDS-1. The sweep lasts exactly WORDS cycles.
- During CLEAR:
  - External writes are dropped and wr_drop pulses.
  - Reads are still serviced, but rd_hit is forced to 0.
- clr_req while in CLEAR is ignored; it does not restart the sweep.
- If clr_req and wr_en arrive in the same IDLE cycle, the clear wins, the write is dropped and wr_drop pulses.
- Reset:
  - FSM goes to IDLE, clr_ptr=0 and all valid bits are cleared.
  - rd_valid=0, rd_hit=0, rd_data=0, wr_drop=0 and clr_busy=0.
  - RAM contents are not cleared. Reset asserted mid-sweep aborts the sweep.

## Timing
- Read latency is 1+OUT_REG cycles from rd_en to rd_valid, i.e. 2 cycles with the defaults. The pipeline is fully pipelined: one read per port per cycle.
- A write at cycle t is visible to a read issued at t (through the bypass) and at any later cycle.
- A read at t followed by a write to the same address at t+1 returns the old data.
- wr_drop asserts in the cycle after the dropped write.
- clr_busy is high from cycle t+1 to cycle t+WORDS inclusive, where t is the cycle clr_req is accepted.
- The first accepted write after clear is the one at cycle t+WORDS+1.

## Structure
- Package pkg_feature_cache_mb holds:
  - the state enum {IDLE, CLEAR};
  - default-parameter constants;
  - a function that unpacks a port slice from a packed address or data bus.
- Sub-module fc_sdp_bank: a simple dual-port RAM with one write port and one read port, inferrable, with registered address. It is instantiated NUM_RD times.
- Valid bits, bypass compare, clear FSM and the output pipeline live in the top level.

## Test plan
- Write 0xA5 at address 5. At the next cycle read address 5 on both ports → rd_valid at +2, rd_data=0xA5, rd_hit=1 on both ports.
- Same-cycle write of 0x3C to address 9 and read of address 9 on port 1 → rd_data=0x3C, rd_hit=1. The old contents must not appear.
- After reset, read address 7 → rd_valid=1, rd_hit=0.
- Sweep with WORDS=16:
  - pulse clr_req → clr_busy high for exactly 16 cycles;
  - a write during the sweep → wr_drop pulses;
  - afterwards, a read of any address → data 0, rd_hit=0.
- clr_req and wr_en(addr 3, 0xFF) in the same cycle → write dropped, wr_drop=1; address 3 later reads 0 with rd_hit=0.
- Assert rst at sweep cycle 4 → clr_busy=0 at the next cycle, FSM in IDLE. An immediate write of 0x11 to address 2 succeeds and reads back as 0x11.
